// File: rtl/gtp_rcv_deframe_if.sv
// Symbol/read/status bundle for the GTP receive deframer.
//   slave  : deframer side (consumes symbols and dout_rd, drives head word and status)
//   master : link/consumer side (drives symbols and dout_rd)
// Signals:
//   datain/kchar         received 16-bit symbol and its K-character flag
//   dout/dout_valid/dout_cw/dout_rd  first-word-fall-through FIFO head and its read strobe
//   trig, err_*          1-clk status pulses
//   blk_cnt              committed block count
interface gtp_rcv_deframe_if;
  logic [15:0] datain;
  logic        kchar;
  logic        trig;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_rd;
  logic        dout_cw;
  logic        err_undr;
  logic        err_ovr;
  logic        err_kchar;
  logic        err_full;
  logic [15:0] blk_cnt;

  modport slave (
    input  datain, kchar, dout_rd,
    output trig, dout, dout_valid, dout_cw,
    output err_undr, err_ovr, err_kchar, err_full, blk_cnt
  );

  modport master (
    output datain, kchar, dout_rd,
    input  trig, dout, dout_valid, dout_cw,
    input  err_undr, err_ovr, err_kchar, err_full, blk_cnt
  );
endinterface

// File: rtl/gtp_rcv_deframe.sv
// Receive-side GTP deframer.
// Extracts trigger K-chars as 1-clk pulses, drops commas, and assembles
// control-word-led blocks into a FIFO. Words become readable only once the
// whole block has been received; aborted or overflowing blocks are rolled back.
// Ports:
//   clk    receive clock
//   reset  synchronous active-high reset
//   bus    gtp_rcv_deframe_if.slave (symbol in, FWFT head out, status pulses)
//
// state | meaning
// IDLE  | waiting for a control word
// DATA  | collecting the payload words of the current block
module gtp_rcv_deframe #(
  parameter int          AW       = 11,
  parameter logic [15:0] CH_COMMA = 16'h00BC,
  parameter logic [15:0] CH_TRIG  = 16'h801C
) (
  input  logic               clk,
  input  logic               reset,
  gtp_rcv_deframe_if.slave   bus
);

  typedef enum logic {IDLE, DATA} state_t;

  state_t         state, state_nxt;
  logic [AW-1:0]  wr_ptr, commit_ptr, commit_vis, rd_ptr;
  logic [AW-1:0]  wr_inc, commit_inc, rd_ptr_nxt;
  logic [8:0]     remaining;
  logic           drop;
  logic [15:0]    mem [0:(1<<AW)-1];

  logic is_trig, is_comma, is_badk, is_cw, is_data;
  logic wr_full, cw_full;

  // next-cycle values produced by the output process
  logic           wr_en;
  logic [AW-1:0]  wr_addr, wr_ptr_nxt, commit_nxt;
  logic [8:0]     remaining_nxt;
  logic           drop_nxt, blk_inc, dropped;
  logic           trig_nxt, undr_nxt, ovr_nxt, kerr_nxt, full_nxt;

  assign is_trig  = bus.kchar && (bus.datain == CH_TRIG);
  assign is_comma = bus.kchar && (bus.datain == CH_COMMA);
  assign is_badk  = bus.kchar && !is_trig && !is_comma;
  assign is_cw    = !bus.kchar && bus.datain[15];
  assign is_data  = !bus.kchar && !bus.datain[15];

  assign wr_inc     = wr_ptr + 1'b1;
  assign commit_inc = commit_ptr + 1'b1;
  assign wr_full    = (wr_inc == rd_ptr);
  // A control word always starts at commit_ptr: in IDLE wr_ptr already equals
  // it, and in DATA the partial block is being rolled back.
  assign cw_full    = (commit_inc == rd_ptr);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (is_badk)
      state_nxt = IDLE;
    else if (is_cw)
      state_nxt = (bus.datain[8:0] == 9'd0) ? IDLE : DATA;
    else if (is_data && state == DATA && remaining == 9'd1)
      state_nxt = IDLE;
  end

  always_comb begin
    wr_en         = 1'b0;
    wr_addr       = wr_ptr;
    wr_ptr_nxt    = wr_ptr;
    commit_nxt    = commit_ptr;
    remaining_nxt = remaining;
    drop_nxt      = drop;
    dropped       = drop;
    blk_inc       = 1'b0;
    trig_nxt      = is_trig;
    undr_nxt      = 1'b0;
    ovr_nxt       = 1'b0;
    kerr_nxt      = 1'b0;
    full_nxt      = 1'b0;
    if (is_badk) begin
      kerr_nxt   = 1'b1;
      wr_ptr_nxt = commit_ptr;
      drop_nxt   = 1'b0;
    end else if (is_cw) begin
      undr_nxt      = (state == DATA);
      remaining_nxt = bus.datain[8:0];
      wr_addr       = commit_ptr;
      drop_nxt      = 1'b0;
      if (cw_full) begin
        full_nxt   = 1'b1;
        drop_nxt   = (bus.datain[8:0] != 9'd0);
        wr_ptr_nxt = commit_ptr;
      end else begin
        wr_en      = 1'b1;
        wr_ptr_nxt = commit_inc;
        if (bus.datain[8:0] == 9'd0) begin
          commit_nxt = commit_inc;
          blk_inc    = 1'b1;
        end
      end
    end else if (is_data) begin
      if (state == IDLE) begin
        ovr_nxt = 1'b1;
      end else begin
        remaining_nxt = remaining - 1'b1;
        if (!drop && wr_full) begin
          full_nxt = 1'b1;
          dropped  = 1'b1;
        end else if (!drop) begin
          wr_en      = 1'b1;
          wr_ptr_nxt = wr_inc;
        end
        drop_nxt = dropped;
        if (remaining == 9'd1) begin
          drop_nxt = 1'b0;
          if (dropped) begin
            wr_ptr_nxt = commit_ptr;
          end else begin
            commit_nxt = wr_inc;
            blk_inc    = 1'b1;
          end
        end
      end
    end
  end

  assign rd_ptr_nxt = rd_ptr + AW'(bus.dout_rd && bus.dout_valid);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= bus.datain;
  end

  // rd_ptr addresses the word currently shown on dout. commit_vis delays the
  // commit pointer one clock so a fresh commit reaches dout_valid two clocks
  // after the last word is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      commit_ptr     <= '0;
      commit_vis     <= '0;
      rd_ptr         <= '0;
      remaining      <= '0;
      drop           <= 1'b0;
      bus.blk_cnt    <= '0;
      bus.trig       <= 1'b0;
      bus.err_undr   <= 1'b0;
      bus.err_ovr    <= 1'b0;
      bus.err_kchar  <= 1'b0;
      bus.err_full   <= 1'b0;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_nxt;
      commit_ptr     <= commit_nxt;
      commit_vis     <= commit_ptr;
      rd_ptr         <= rd_ptr_nxt;
      remaining      <= remaining_nxt;
      drop           <= drop_nxt;
      bus.blk_cnt    <= bus.blk_cnt + 16'(blk_inc);
      bus.trig       <= trig_nxt;
      bus.err_undr   <= undr_nxt;
      bus.err_ovr    <= ovr_nxt;
      bus.err_kchar  <= kerr_nxt;
      bus.err_full   <= full_nxt;
      bus.dout       <= mem[rd_ptr_nxt];
      bus.dout_valid <= (rd_ptr_nxt != commit_vis);
    end
  end

  assign bus.dout_cw = bus.dout_valid && bus.dout[15];

endmodule
